// File: rtl/mem_stage_pkg.sv
// Shared types and access-size helpers for the memory stage.
package mem_stage_pkg;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    // Access width in bytes; encodings not available at this XLEN fall back to a word.
    function automatic logic [3:0] size_bytes(input logic [2:0] f3, input int unsigned xlen);
        logic [3:0] sz;
        case (f3)
            F3_B, F3_BU: sz = 4'd1;
            F3_H, F3_HU: sz = 4'd2;
            F3_D:        sz = (xlen == 64) ? 4'd8 : 4'd4;
            default:     sz = 4'd4;
        endcase
        return sz;
    endfunction

    function automatic logic is_signed(input logic [2:0] f3, input int unsigned xlen);
        logic s;
        case (f3)
            F3_BU, F3_HU: s = 1'b0;
            F3_WU:        s = (xlen != 64);
            default:      s = 1'b1;
        endcase
        return s;
    endfunction

    function automatic logic is_aligned(input logic [2:0] addr_lo, input logic [2:0] f3,
                                        input int unsigned xlen);
        logic ok;
        case (size_bytes(f3, xlen))
            4'd2:    ok = (addr_lo[0] == 1'b0);
            4'd4:    ok = (addr_lo[1:0] == 2'b00);
            4'd8:    ok = (addr_lo == 3'b000);
            default: ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store data/byte-enable placement and load extraction with extension.
module lsu_align
    import mem_stage_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [$clog2(XLEN/8)-1:0] st_addr_lo,
    input  logic [2:0]                st_funct3,
    input  logic [XLEN-1:0]           st_data,
    output logic [XLEN/8-1:0]         st_be,
    output logic [XLEN-1:0]           st_wdata,
    input  logic [$clog2(XLEN/8)-1:0] ld_addr_lo,
    input  logic [2:0]                ld_funct3,
    input  logic [XLEN-1:0]           ld_rdata,
    output logic [XLEN-1:0]           ld_data
);

    localparam int unsigned NB = XLEN / 8;

    logic [3:0]      st_size;
    logic [15:0]     be_base;
    logic [3:0]      ld_size;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] mask;
    logic [XLEN-1:0] top_bit;
    logic            sign;

    always_comb begin
        st_size  = size_bytes(st_funct3, XLEN);
        be_base  = (16'(1) << st_size) - 16'(1);
        st_be    = NB'(be_base << st_addr_lo);
        st_wdata = st_data << {st_addr_lo, 3'b000};
    end

    // The sign bit is the top set bit of the size mask, so no variable bit-select is needed.
    always_comb begin
        ld_size = size_bytes(ld_funct3, XLEN);
        shifted = ld_rdata >> {ld_addr_lo, 3'b000};
        if (32'(ld_size) >= NB) begin
            mask = '1;
        end else begin
            mask = (XLEN'(1) << {ld_size, 3'b000}) - XLEN'(1);
        end
        top_bit = mask & ~(mask >> 1);
        sign    = is_signed(ld_funct3, XLEN) && (|(shifted & top_bit));
        ld_data = sign ? (shifted | ~mask) : (shifted & mask);
    end

endmodule

// File: rtl/mem_stage_hs.sv
// RISC-V memory stage with request/grant/response handshake and writeback register.
module mem_stage_hs
    import mem_stage_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RD_W = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ex_valid,
    input  logic [XLEN-1:0]     alu_result_from_execution,
    input  logic                flag_zero_from_execution,
    input  logic [XLEN-1:0]     add_sum_from_execution,
    input  logic [XLEN-1:0]     read_data_2_from_execution,
    input  logic [RD_W-1:0]     immed_11_7_from_execution,
    input  logic [2:0]          funct3,
    input  logic                mem_read_control,
    input  logic                mem_write_control,
    input  logic                branch_control,
    output logic                mem_stall,
    output logic                mc_req,
    output logic                mc_we,
    output logic [XLEN-1:0]     mc_addr,
    output logic [XLEN/8-1:0]   mc_be,
    output logic [XLEN-1:0]     mc_wdata,
    input  logic                mc_gnt,
    input  logic                mc_rvalid,
    input  logic [XLEN-1:0]     mc_rdata,
    output logic                wb_valid,
    output logic [XLEN-1:0]     read_data_from_memory,
    output logic [XLEN-1:0]     alu_result_from_memory,
    output logic [RD_W-1:0]     immed_11_7_from_memory,
    output logic [XLEN-1:0]     add_sum_from_memory,
    output logic                PCSrc_from_memory,
    output logic                misaligned
);

    localparam int unsigned NB     = XLEN / 8;
    localparam int unsigned LANE_W = $clog2(NB);

    state_e            state_q, state_d;
    logic              mem_stall_q, mem_stall_d;
    logic              mc_req_q, mc_req_d;
    logic              mc_we_q, mc_we_d;
    logic [XLEN-1:0]   mc_addr_q, mc_addr_d;
    logic [NB-1:0]     mc_be_q, mc_be_d;
    logic [XLEN-1:0]   mc_wdata_q, mc_wdata_d;
    logic              wb_valid_q, wb_valid_d;
    logic [XLEN-1:0]   read_data_q, read_data_d;
    logic [XLEN-1:0]   alu_q, alu_d;
    logic [RD_W-1:0]   rd_q, rd_d;
    logic [XLEN-1:0]   add_sum_q, add_sum_d;
    logic              pcsrc_q, pcsrc_d;
    logic              misaligned_q, misaligned_d;
    logic [2:0]        funct3_q, funct3_d;
    logic              is_load_q, is_load_d;

    logic              mem_op_c;
    logic              aligned_c;
    logic [NB-1:0]     st_be_c;
    logic [XLEN-1:0]   st_wdata_c;
    logic [XLEN-1:0]   ld_data_c;

    // Store lanes come from the live execute inputs; load lanes from the held access.
    lsu_align #(.XLEN(XLEN)) u_align (
        .st_addr_lo (alu_result_from_execution[LANE_W-1:0]),
        .st_funct3  (funct3),
        .st_data    (read_data_2_from_execution),
        .st_be      (st_be_c),
        .st_wdata   (st_wdata_c),
        .ld_addr_lo (alu_q[LANE_W-1:0]),
        .ld_funct3  (funct3_q),
        .ld_rdata   (mc_rdata),
        .ld_data    (ld_data_c)
    );

    assign mem_op_c  = mem_read_control | mem_write_control;
    assign aligned_c = is_aligned(alu_result_from_execution[2:0], funct3, XLEN);

    always_comb begin
        state_d      = state_q;
        mc_req_d     = mc_req_q;
        mc_we_d      = mc_we_q;
        mc_addr_d    = mc_addr_q;
        mc_be_d      = mc_be_q;
        mc_wdata_d   = mc_wdata_q;
        read_data_d  = read_data_q;
        alu_d        = alu_q;
        rd_d         = rd_q;
        add_sum_d    = add_sum_q;
        pcsrc_d      = pcsrc_q;
        misaligned_d = misaligned_q;
        funct3_d     = funct3_q;
        is_load_d    = is_load_q;

        case (state_q)
            IDLE, DONE: begin
                if (ex_valid) begin
                    alu_d        = alu_result_from_execution;
                    rd_d         = immed_11_7_from_execution;
                    add_sum_d    = add_sum_from_execution;
                    pcsrc_d      = branch_control & flag_zero_from_execution;
                    funct3_d     = funct3;
                    is_load_d    = mem_read_control;
                    read_data_d  = '0;
                    misaligned_d = mem_op_c & ~aligned_c;
                    if (mem_op_c && aligned_c) begin
                        state_d    = REQ;
                        mc_req_d   = 1'b1;
                        mc_we_d    = mem_write_control;
                        mc_addr_d  = {alu_result_from_execution[XLEN-1:LANE_W], LANE_W'(0)};
                        mc_be_d    = st_be_c;
                        mc_wdata_d = mem_write_control ? st_wdata_c : '0;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (mc_gnt) begin
                    mc_req_d   = 1'b0;
                    mc_we_d    = 1'b0;
                    mc_addr_d  = '0;
                    mc_be_d    = '0;
                    mc_wdata_d = '0;
                    if (!is_load_q) begin
                        state_d = DONE;
                    end else if (mc_rvalid) begin
                        state_d     = DONE;
                        read_data_d = ld_data_c;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (mc_rvalid) begin
                    state_d     = DONE;
                    read_data_d = ld_data_c;
                end
            end
            default: state_d = IDLE;
        endcase

        wb_valid_d  = (state_d == DONE);
        mem_stall_d = (state_d == REQ) || (state_d == WAIT);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            mem_stall_q  <= 1'b0;
            mc_req_q     <= 1'b0;
            mc_we_q      <= 1'b0;
            mc_addr_q    <= '0;
            mc_be_q      <= '0;
            mc_wdata_q   <= '0;
            wb_valid_q   <= 1'b0;
            read_data_q  <= '0;
            alu_q        <= '0;
            rd_q         <= '0;
            add_sum_q    <= '0;
            pcsrc_q      <= 1'b0;
            misaligned_q <= 1'b0;
            funct3_q     <= '0;
            is_load_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_stall_q  <= mem_stall_d;
            mc_req_q     <= mc_req_d;
            mc_we_q      <= mc_we_d;
            mc_addr_q    <= mc_addr_d;
            mc_be_q      <= mc_be_d;
            mc_wdata_q   <= mc_wdata_d;
            wb_valid_q   <= wb_valid_d;
            read_data_q  <= read_data_d;
            alu_q        <= alu_d;
            rd_q         <= rd_d;
            add_sum_q    <= add_sum_d;
            pcsrc_q      <= pcsrc_d;
            misaligned_q <= misaligned_d;
            funct3_q     <= funct3_d;
            is_load_q    <= is_load_d;
        end
    end

    assign mem_stall              = mem_stall_q;
    assign mc_req                 = mc_req_q;
    assign mc_we                  = mc_we_q;
    assign mc_addr                = mc_addr_q;
    assign mc_be                  = mc_be_q;
    assign mc_wdata               = mc_wdata_q;
    assign wb_valid               = wb_valid_q;
    assign read_data_from_memory  = read_data_q;
    assign alu_result_from_memory = alu_q;
    assign immed_11_7_from_memory = rd_q;
    assign add_sum_from_memory    = add_sum_q;
    assign PCSrc_from_memory      = pcsrc_q;
    assign misaligned             = misaligned_q;

endmodule

// File: tb/tb_mem_stage_hs.sv
// Directed self-checking bench for mem_stage_hs at XLEN=32.
module tb_mem_stage_hs;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [31:0] alu_in;
    logic        zero_in;
    logic [31:0] add_sum_in;
    logic [31:0] rd2_in;
    logic [4:0]  rd_in;
    logic [2:0]  funct3;
    logic        mem_read, mem_write, branch;
    logic        mem_stall, mc_req, mc_we;
    logic [31:0] mc_addr;
    logic [3:0]  mc_be;
    logic [31:0] mc_wdata;
    logic        mc_gnt, mc_rvalid;
    logic [31:0] mc_rdata;
    logic        wb_valid;
    logic [31:0] read_data, alu_out, add_sum_out;
    logic [4:0]  rd_out;
    logic        pcsrc, misaligned;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_stage_hs #(.XLEN(32), .RD_W(5)) dut (
        .clk                        (clk),
        .rst                        (rst),
        .ex_valid                   (ex_valid),
        .alu_result_from_execution  (alu_in),
        .flag_zero_from_execution   (zero_in),
        .add_sum_from_execution     (add_sum_in),
        .read_data_2_from_execution (rd2_in),
        .immed_11_7_from_execution  (rd_in),
        .funct3                     (funct3),
        .mem_read_control           (mem_read),
        .mem_write_control          (mem_write),
        .branch_control             (branch),
        .mem_stall                  (mem_stall),
        .mc_req                     (mc_req),
        .mc_we                      (mc_we),
        .mc_addr                    (mc_addr),
        .mc_be                      (mc_be),
        .mc_wdata                   (mc_wdata),
        .mc_gnt                     (mc_gnt),
        .mc_rvalid                  (mc_rvalid),
        .mc_rdata                   (mc_rdata),
        .wb_valid                   (wb_valid),
        .read_data_from_memory      (read_data),
        .alu_result_from_memory     (alu_out),
        .immed_11_7_from_memory     (rd_out),
        .add_sum_from_memory        (add_sum_out),
        .PCSrc_from_memory          (pcsrc),
        .misaligned                 (misaligned)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ex_idle();
        ex_valid   = 1'b0;
        alu_in     = '0;
        zero_in    = 1'b0;
        add_sum_in = '0;
        rd2_in     = '0;
        rd_in      = '0;
        funct3     = 3'b000;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        branch     = 1'b0;
    endtask

    task automatic ex_mem(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] data);
        ex_idle();
        ex_valid  = 1'b1;
        mem_read  = rd;
        mem_write = wr;
        funct3    = f3;
        alu_in    = addr;
        rd2_in    = data;
        rd_in     = 5'd7;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b0;
        mc_gnt    = 1'b0;
        mc_rvalid = 1'b0;
        mc_rdata  = '0;
        ex_idle();
        step();
        step();

        // Reset state
        chk("rst_mc_req",    64'(mc_req), 64'h0);
        chk("rst_stall",     64'(mem_stall), 64'h0);
        chk("rst_wb_valid",  64'(wb_valid), 64'h0);
        chk("rst_read_data", 64'(read_data), 64'h0);
        chk("rst_alu",       64'(alu_out), 64'h0);
        chk("rst_pcsrc",     64'(pcsrc), 64'h0);
        rst = 1'b1;
        step();

        // Non-memory op
        ex_idle();
        ex_valid   = 1'b1;
        alu_in     = 32'h0000_1234;
        rd_in      = 5'd5;
        branch     = 1'b1;
        zero_in    = 1'b1;
        add_sum_in = 32'h0000_2000;
        step();
        ex_idle();
        chk("alu_wb_valid", 64'(wb_valid), 64'h1);
        chk("alu_result",   64'(alu_out), 64'h1234);
        chk("alu_rd",       64'(rd_out), 64'h5);
        chk("alu_pcsrc",    64'(pcsrc), 64'h1);
        chk("alu_add_sum",  64'(add_sum_out), 64'h2000);
        chk("alu_no_req",   64'(mc_req), 64'h0);
        chk("alu_no_stall", 64'(mem_stall), 64'h0);
        step();
        chk("alu_wb_pulse", 64'(wb_valid), 64'h0);

        // LW 0x100, grant on 3rd request cycle, rvalid two cycles later
        ex_mem(1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
        step();
        ex_idle();
        chk("lw_req1",   64'(mc_req), 64'h1);
        chk("lw_stall1", 64'(mem_stall), 64'h1);
        chk("lw_addr1",  64'(mc_addr), 64'h100);
        chk("lw_be",     64'(mc_be), 64'hF);
        chk("lw_we",     64'(mc_we), 64'h0);
        mc_rvalid = 1'b1;
        mc_rdata  = 32'h1111_1111;
        step();
        mc_rvalid = 1'b0;
        chk("lw_req2",       64'(mc_req), 64'h1);
        chk("lw_addr2",      64'(mc_addr), 64'h100);
        chk("lw_rv_nogntwb", 64'(wb_valid), 64'h0);
        step();
        chk("lw_req3",   64'(mc_req), 64'h1);
        chk("lw_addr3",  64'(mc_addr), 64'h100);
        mc_gnt = 1'b1;
        step();
        mc_gnt = 1'b0;
        chk("lw_wait_req",   64'(mc_req), 64'h0);
        chk("lw_wait_stall", 64'(mem_stall), 64'h1);
        chk("lw_wait_wb",    64'(wb_valid), 64'h0);
        step();
        chk("lw_wait_stall2", 64'(mem_stall), 64'h1);
        mc_rvalid = 1'b1;
        mc_rdata  = 32'hDEAD_BEEF;
        step();
        mc_rvalid = 1'b0;
        chk("lw_wb_valid", 64'(wb_valid), 64'h1);
        chk("lw_data",     64'(read_data), 64'hDEAD_BEEF);
        chk("lw_stall_off", 64'(mem_stall), 64'h0);
        chk("lw_aligned",  64'(misaligned), 64'h0);
        step();
        chk("lw_wb_pulse", 64'(wb_valid), 64'h0);

        // LB 0x103 then back-to-back LBU, zero-wait controller
        ex_mem(1'b1, 1'b0, 3'b000, 32'h103, 32'h0);
        step();
        ex_idle();
        chk("lb_be",   64'(mc_be), 64'h8);
        chk("lb_addr", 64'(mc_addr), 64'h100);
        chk("lb_wb_early", 64'(wb_valid), 64'h0);
        mc_gnt    = 1'b1;
        mc_rvalid = 1'b1;
        mc_rdata  = 32'h80FF_FFFF;
        step();
        mc_gnt    = 1'b0;
        mc_rvalid = 1'b0;
        chk("lb_wb_valid", 64'(wb_valid), 64'h1);
        chk("lb_data",     64'(read_data), 64'hFFFF_FF80);
        ex_mem(1'b1, 1'b0, 3'b100, 32'h103, 32'h0);
        step();
        ex_idle();
        chk("lbu_wb_pulse", 64'(wb_valid), 64'h0);
        chk("lbu_req",      64'(mc_req), 64'h1);
        mc_gnt    = 1'b1;
        mc_rvalid = 1'b1;
        mc_rdata  = 32'h80FF_FFFF;
        step();
        mc_gnt    = 1'b0;
        mc_rvalid = 1'b0;
        chk("lbu_wb_valid", 64'(wb_valid), 64'h1);
        chk("lbu_data",     64'(read_data), 64'h0000_0080);
        step();

        // SH 0x102
        ex_mem(1'b0, 1'b1, 3'b001, 32'h102, 32'h0000_ABCD);
        step();
        ex_idle();
        chk("sh_req",   64'(mc_req), 64'h1);
        chk("sh_we",    64'(mc_we), 64'h1);
        chk("sh_be",    64'(mc_be), 64'hC);
        chk("sh_addr",  64'(mc_addr), 64'h100);
        chk("sh_wdata", 64'(mc_wdata), 64'hABCD_0000);
        mc_gnt = 1'b1;
        step();
        mc_gnt = 1'b0;
        chk("sh_wb_valid", 64'(wb_valid), 64'h1);
        chk("sh_req_off",  64'(mc_req), 64'h0);
        chk("sh_rdata0",   64'(read_data), 64'h0);

        // Misaligned LW 0x101, accepted straight from DONE
        ex_mem(1'b1, 1'b0, 3'b010, 32'h101, 32'h0);
        step();
        ex_idle();
        chk("mis_req",      64'(mc_req), 64'h0);
        chk("mis_wb_valid", 64'(wb_valid), 64'h1);
        chk("mis_flag",     64'(misaligned), 64'h1);
        chk("mis_data",     64'(read_data), 64'h0);
        chk("mis_stall",    64'(mem_stall), 64'h0);
        step();

        // Reset during WAIT, then a late rvalid
        ex_mem(1'b1, 1'b0, 3'b010, 32'h200, 32'h0);
        step();
        ex_idle();
        mc_gnt = 1'b1;
        step();
        mc_gnt = 1'b0;
        chk("wr_wait_stall", 64'(mem_stall), 64'h1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("wr_req",   64'(mc_req), 64'h0);
        chk("wr_stall", 64'(mem_stall), 64'h0);
        chk("wr_wb",    64'(wb_valid), 64'h0);
        chk("wr_alu",   64'(alu_out), 64'h0);
        chk("wr_addr",  64'(mc_addr), 64'h0);
        mc_rvalid = 1'b1;
        mc_rdata  = 32'h1234_5678;
        step();
        mc_rvalid = 1'b0;
        chk("late_rv_wb",    64'(wb_valid), 64'h0);
        chk("late_rv_data",  64'(read_data), 64'h0);
        chk("late_rv_stall", 64'(mem_stall), 64'h0);
        step();
        chk("late_rv_wb2",   64'(wb_valid), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
